// File: rtl/mcs4_rom_responder.sv
// mcs4_rom_responder: host-loadable program memory on the MCS-4 4-bit bus.
// Follows the 8-subcycle instruction cycle from sync/clken_2, assembles the
// 12-bit fetch address over A1-A3 and drives the addressed byte in M1/M2.
// Optional PC trace port: define MCS4_ROM_TRACE_EN.
module mcs4_rom_responder #(
    parameter logic [3:0]  CHIP_BASE = 4'h0,
    parameter int unsigned NUM_CHIPS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clken_1,
    input  logic                             clken_2,
    input  logic                             sync,
    input  logic                             cm_rom,
    input  logic [3:0]                       dbus_in,
    output logic [3:0]                       dbus_out,
    input  logic                             load_en,
    input  logic [$clog2(NUM_CHIPS)+7:0]     load_addr,
    input  logic [7:0]                       load_data,
    output logic                             fetch_active
`ifdef MCS4_ROM_TRACE_EN
    ,
    output logic                             trace_valid,
    output logic [11:0]                      trace_addr,
    output logic [7:0]                       trace_data
`endif
);

    localparam int unsigned AW    = $clog2(NUM_CHIPS) + 8;
    localparam int unsigned AW1   = AW + 1;
    localparam int unsigned DEPTH = NUM_CHIPS * 256;
    localparam logic [AW:0] DEPTH_W = AW1'(DEPTH);
    localparam logic [4:0]  NUM_W   = 5'(NUM_CHIPS);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_A1   = 4'd1,
        ST_A2   = 4'd2,
        ST_A3   = 4'd3,
        ST_M1   = 4'd4,
        ST_M2   = 4'd5,
        ST_X1   = 4'd6,
        ST_X2   = 4'd7,
        ST_X3   = 4'd8
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [11:0]    r_addr;
    logic           r_sel;
    logic [7:0]     r_data_q;
    logic [7:0]     r_mem [0:DEPTH-1];

    logic [3:0]     w_chip_off;
    logic           w_in_range;
    logic           w_hit;
    logic           w_a3_end;
    logic [AW-1:0]  w_rd_idx;
    logic           w_load_ok;

    // Chip decode on the A3 nibble, which is still on the bus at the A3-ending edge
    assign w_chip_off = dbus_in - CHIP_BASE;
    assign w_in_range = ({1'b0, w_chip_off} < NUM_W);
    assign w_a3_end   = clken_2 && !sync && (r_state == ST_A3);
    assign w_hit      = cm_rom && w_in_range;
    assign w_rd_idx   = AW'({w_chip_off, r_addr[7:0]});
    assign w_load_ok  = load_en && ({1'b0, load_addr} < DEPTH_W);

    // Subcycle state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Subcycle sequencing: sync restarts at A1 from anywhere, X3 holds until sync
    always_comb begin
        w_state_nxt = r_state;
        if (clken_2) begin
            if (sync) begin
                w_state_nxt = ST_A1;
            end else begin
                case (r_state)
                    ST_IDLE: w_state_nxt = ST_IDLE;
                    ST_A1:   w_state_nxt = ST_A2;
                    ST_A2:   w_state_nxt = ST_A3;
                    ST_A3:   w_state_nxt = ST_M1;
                    ST_M1:   w_state_nxt = ST_M2;
                    ST_M2:   w_state_nxt = ST_X1;
                    ST_X1:   w_state_nxt = ST_X2;
                    ST_X2:   w_state_nxt = ST_X3;
                    ST_X3:   w_state_nxt = ST_X3;
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // Address capture, chip select and registered memory read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_sel    <= 1'b0;
            r_data_q <= '0;
        end else if (clken_2) begin
            if (sync) begin
                r_sel <= 1'b0;
            end else begin
                case (r_state)
                    ST_A1: r_addr[3:0] <= dbus_in;
                    ST_A2: r_addr[7:4] <= dbus_in;
                    ST_A3: begin
                        r_addr[11:8] <= dbus_in;
                        r_sel        <= w_hit;
                        if (w_in_range) begin
                            r_data_q <= r_mem[w_rd_idx];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Host write port; contents survive reset and old data is seen by a same-edge fetch
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem[load_addr] <= load_data;
        end
    end

    // Bus drive decoded from registered state so it only moves on clken_2 edges or reset
    always_comb begin
        dbus_out     = 4'h0;
        fetch_active = 1'b0;
        if (r_sel) begin
            case (r_state)
                ST_M1: begin
                    dbus_out     = r_data_q[7:4];
                    fetch_active = 1'b1;
                end
                ST_M2: begin
                    dbus_out     = r_data_q[3:0];
                    fetch_active = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MCS4_ROM_TRACE_EN
    logic r_trace_valid;

    // One-clk trace pulse at the A3-ending edge of each selected fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trace_valid <= 1'b0;
        end else begin
            r_trace_valid <= w_a3_end && w_hit;
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_addr  = r_addr;
    assign trace_data  = r_data_q;

    logic w_unused_bits;
    assign w_unused_bits = clken_1;
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{clken_1, r_addr[11:8], w_a3_end};
`endif

endmodule

// File: tb/tb_mcs4_rom_responder.sv
// Directed bench for mcs4_rom_responder: two instances (base 0 / 4 chips and
// base 2 / 2 chips) share the CPU bus; expectations go through a queue.
module tb_mcs4_rom_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        clken_1, clken_2, sync, cm_rom;
    logic [3:0]  dbus_in;
    logic [3:0]  dout0, dout1;
    logic        fa0, fa1;
    logic        ld0_en, ld1_en;
    logic [9:0]  ld0_addr;
    logic [8:0]  ld1_addr;
    logic [7:0]  ld0_data, ld1_data;
`ifdef MCS4_ROM_TRACE_EN
    logic        tv0, tv1;
    logic [11:0] ta0, ta1;
    logic [7:0]  td0, td1;
`endif

    always #5 clk = ~clk;

    mcs4_rom_responder #(.CHIP_BASE(4'h0), .NUM_CHIPS(4)) dut0 (
        .clk(clk), .rst(rst), .clken_1(clken_1), .clken_2(clken_2),
        .sync(sync), .cm_rom(cm_rom), .dbus_in(dbus_in), .dbus_out(dout0),
        .load_en(ld0_en), .load_addr(ld0_addr), .load_data(ld0_data),
        .fetch_active(fa0)
`ifdef MCS4_ROM_TRACE_EN
        , .trace_valid(tv0), .trace_addr(ta0), .trace_data(td0)
`endif
    );

    mcs4_rom_responder #(.CHIP_BASE(4'h2), .NUM_CHIPS(2)) dut1 (
        .clk(clk), .rst(rst), .clken_1(clken_1), .clken_2(clken_2),
        .sync(sync), .cm_rom(cm_rom), .dbus_in(dbus_in), .dbus_out(dout1),
        .load_en(ld1_en), .load_addr(ld1_addr), .load_data(ld1_data),
        .fetch_active(fa1)
`ifdef MCS4_ROM_TRACE_EN
        , .trace_valid(tv1), .trace_addr(ta1), .trace_data(td1)
`endif
    );

    typedef struct {
        logic [3:0]  d0;
        logic        f0;
        logic [3:0]  d1;
        logic        f1;
        logic        tv;
        logic [11:0] ta;
        logic [7:0]  td;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m0 [int];
    logic [7:0]  m1 [int];
    logic        s0, s1;
    logic [7:0]  b0, b1;
    logic [11:0] cur_a;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.d0 = 4'h0; e.f0 = 1'b0; e.d1 = 4'h0; e.f1 = 1'b0;
        e.tv = 1'b0; e.ta = 12'h000; e.td = 8'h00;
        return e;
    endfunction

    // Pop the oldest expectation and compare against both instances
    task automatic check_front(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 12'd1, 12'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_dout0"}, 12'(dout0), 12'(e.d0));
            chk({tag, "_fa0"},   12'(fa0),   12'(e.f0));
            chk({tag, "_dout1"}, 12'(dout1), 12'(e.d1));
            chk({tag, "_fa1"},   12'(fa1),   12'(e.f1));
`ifdef MCS4_ROM_TRACE_EN
            chk({tag, "_tv0"}, 12'(tv0), 12'(e.tv));
            if (e.tv) begin
                chk({tag, "_ta0"}, ta0, e.ta);
                chk({tag, "_td0"}, 12'(td0), 12'(e.td));
            end
`endif
        end
    endtask

    // One subcycle: present bus values, clken_1 pulse, then clken_2 pulse
    task automatic step(input string tag, input logic [3:0] nib, input logic sy,
                        input logic cm, input logic wr, input exp_t e);
        sb.push_back(e);
        @(negedge clk);
        dbus_in = nib; sync = sy; cm_rom = cm; clken_1 = 1'b1;
        @(negedge clk);
        clken_1 = 1'b0; clken_2 = 1'b1;
        if (wr) begin
            ld0_en = 1'b1; ld0_addr = 10'h010; ld0_data = 8'h77;
        end
        @(negedge clk);
        clken_2 = 1'b0; ld0_en = 1'b0;
        check_front(tag);
    endtask

    task automatic load0(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        ld0_en = 1'b1; ld0_addr = a; ld0_data = d;
        @(negedge clk);
        ld0_en = 1'b0;
        m0[int'(a)] = d;
    endtask

    task automatic load1(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        ld1_en = 1'b1; ld1_addr = a; ld1_data = d;
        @(negedge clk);
        ld1_en = 1'b0;
        m1[int'(a)] = d;
    endtask

    function automatic logic [7:0] rd(input logic [7:0] m [int], input int idx);
        if (m.exists(idx)) return m[idx];
        return 8'h00;
    endfunction

    // Sync (optional), A1, A2, A3; ends with the instance outputs in M1
    task automatic head(input logic [11:0] a, input logic cm, input logic wr, input logic do_sync);
        exp_t e;
        int   chip;
        chip  = int'(a[11:8]);
        cur_a = a;
        s0 = cm && (chip >= 0) && (chip < 0 + 4);
        s1 = cm && (chip >= 2) && (chip < 2 + 2);
        b0 = s0 ? rd(m0, (chip - 0) * 256 + int'(a[7:0])) : 8'h00;
        b1 = s1 ? rd(m1, (chip - 2) * 256 + int'(a[7:0])) : 8'h00;
        if (do_sync) step("sync", 4'h0, 1'b1, 1'b0, 1'b0, idle_exp());
        step("a1", a[3:0], 1'b0, 1'b0, 1'b0, idle_exp());
        step("a2", a[7:4], 1'b0, 1'b0, 1'b0, idle_exp());
        e = idle_exp();
        e.d0 = s0 ? b0[7:4] : 4'h0; e.f0 = s0;
        e.d1 = s1 ? b1[7:4] : 4'h0; e.f1 = s1;
        e.tv = s0; e.ta = a; e.td = b0;
        step("m1", a[11:8], 1'b0, cm, wr, e);
        if (wr) m0[16] = 8'h77;
    endtask

    // M2 then X1..X3
    task automatic tail();
        exp_t e;
        e = idle_exp();
        e.d0 = s0 ? b0[3:0] : 4'h0; e.f0 = s0;
        e.d1 = s1 ? b1[3:0] : 4'h0; e.f1 = s1;
        step("m2", 4'h0, 1'b0, 1'b0, 1'b0, e);
        step("x1", 4'h0, 1'b0, 1'b0, 1'b0, idle_exp());
        step("x2", 4'h0, 1'b0, 1'b0, 1'b0, idle_exp());
        step("x3", 4'h0, 1'b0, 1'b0, 1'b0, idle_exp());
    endtask

    task automatic fetch(input logic [11:0] a, input logic cm, input logic wr);
        head(a, cm, wr, 1'b1);
        tail();
    endtask

    initial begin
        rst = 1'b1; clken_1 = 1'b0; clken_2 = 1'b0; sync = 1'b0; cm_rom = 1'b0;
        dbus_in = 4'h0;
        ld0_en = 1'b0; ld0_addr = '0; ld0_data = '0;
        ld1_en = 1'b0; ld1_addr = '0; ld1_data = '0;
        repeat (2) @(negedge clk);
        sb.push_back(idle_exp());
        check_front("reset");
        rst = 1'b0;

        load0(10'h000, 8'hD5);
        load0(10'h001, 8'h2A);
        load0(10'h010, 8'h11);
        load0(10'h3FF, 8'h99);
        load1(9'h1FF, 8'h3C);

        fetch(12'h000, 1'b1, 1'b0);   // D / 5
        fetch(12'h001, 1'b1, 1'b0);   // 2 / A
        fetch(12'h512, 1'b1, 1'b0);   // no chip answers
        fetch(12'h3FF, 1'b1, 1'b0);   // dut1: 3 / C, dut0: 9 / 9
        fetch(12'h0A0, 1'b0, 1'b0);   // cm_rom low: nobody drives
        fetch(12'h010, 1'b1, 1'b1);   // same-edge write: old 1 / 1
        fetch(12'h010, 1'b1, 1'b0);   // new 7 / 7

        // Early sync in M1 aborts; the restarted cycle fetches normally
        head(12'h000, 1'b1, 1'b0, 1'b1);
        step("abort", 4'h0, 1'b1, 1'b0, 1'b0, idle_exp());
        head(12'h001, 1'b1, 1'b0, 1'b0);
        tail();

        // Reset pulse during M1 of a selected fetch
        head(12'h001, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        sb.push_back(idle_exp());
        check_front("rst_m1");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst0", 4'h0, 1'b0, 1'b0, 1'b0, idle_exp());
        step("post_rst1", 4'h0, 1'b0, 1'b1, 1'b0, idle_exp());
        step("post_rst2", 4'h0, 1'b0, 1'b0, 1'b0, idle_exp());
        fetch(12'h000, 1'b1, 1'b0);

        chk("sb_drained", 12'(sb.size()), 12'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
